// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a PC over a combinational instruction memory
// and buffers fetched words in a 2-entry FIFO in front of the decoder.
module fetch_ctrl #(
    parameter int         MEM_DEPTH = 10,
    parameter logic [3:0] HALT_OP   = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [8:0]  mem_addr,
    input  logic [15:0] mem_inst,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [15:0] dec_inst,
    output logic [8:0]  dec_pc,
    input  logic        redirect,
    input  logic [8:0]  redirect_addr,
    output logic        halted,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    localparam logic [8:0] LAST_PC = 9'(MEM_DEPTH - 1);

    state_t      state, state_next;
    logic [8:0]  pc, pc_next, pc_inc, redirect_pc;
    logic [15:0] buf_inst [2];
    logic [8:0]  buf_pc   [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        pop, push, flush;

    assign pc_inc      = (pc == LAST_PC) ? 9'd0 : pc + 9'd1;
    assign redirect_pc = ({1'b0, redirect_addr} >= 10'(MEM_DEPTH)) ? 9'd0 : redirect_addr;

    assign pop   = (count != 2'd0) && dec_ready;
    assign flush = redirect && (state != IDLE);
    assign push  = (state == FETCH) && !redirect && ((count != 2'd2) || pop);

    assign mem_addr  = pc;
    assign dec_valid = (count != 2'd0);
    assign dec_inst  = buf_inst[rd_ptr];
    assign dec_pc    = buf_pc[rd_ptr];
    assign halted    = (state == HALT);
    assign busy      = (state == FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= 9'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect outranks start everywhere; in IDLE it only retargets the PC.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                end else if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                end else if (push) begin
                    pc_next = pc_inc;
                    if (mem_inst[15:12] == HALT_OP) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (start) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Payload storage needs no reset; dec_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= mem_inst;
            buf_pc[wr_ptr]   <= pc;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 10: number of valid instruction words; the PC wraps from MEM_DEPTH-1 to 0.
REQ-002 Parameter HALT_OP, default 4'b1111: opcode in inst[15:12] that halts fetching.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins fetching from IDLE or resumes from HALT.
REQ-006 mem_addr  output  9  read address to the combinational instruction memory; always equals the PC register.
REQ-007 mem_inst  input  16  instruction returned by memory for mem_addr in the same cycle.
REQ-008 dec_valid  output  1  the buffer head holds an instruction for the decoder.
REQ-009 dec_ready  input  1  decoder accepts the head this cycle.
REQ-010 dec_inst  output  16  instruction at the buffer head.
REQ-011 dec_pc  output  9  address from which dec_inst was fetched.
REQ-012 redirect  input  1  branch/jump request; flushes the buffer and reloads the PC.
REQ-013 redirect_addr  input  9  target address, sampled when redirect=1.
REQ-014 halted  output  1  high while in state HALT.
REQ-015 busy  output  1  high while in state FETCH.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and HALT.
REQ-017 IDLE SHALL go to FETCH on start; FETCH SHALL go to HALT on a push of a HALT_OP instruction; HALT SHALL go to FETCH on start or redirect.
REQ-018 The block SHALL hold a 2-entry FIFO of {inst, pc}; a pop occurs when dec_valid=1 and dec_ready=1.
REQ-019 dec_valid SHALL be 1 exactly when the FIFO count is nonzero; dec_inst and dec_pc SHALL be combinational from the head entry.
REQ-020 In FETCH, the block SHALL push {mem_inst, PC} and advance the PC when count<2, or when count==2 and a pop occurs in the same cycle.
REQ-021 PC advance SHALL be PC+1, or 0 when PC==MEM_DEPTH-1; no other PC arithmetic is performed.
REQ-022 When no push occurs (FIFO full with no pop, IDLE or HALT), the PC and mem_addr SHALL hold.
REQ-023 A HALT_OP instruction SHALL be pushed and the PC advanced normally; FETCH SHALL then go to HALT, and no further pushes occur.
REQ-024 In HALT and IDLE, the FIFO SHALL continue to drain through pops.
REQ-025 On start in HALT, fetching SHALL resume at the current PC (halt address+1, with wrap).
REQ-026 Redirect in FETCH or HALT SHALL take effect at the next edge: FIFO count cleared, PC set to redirect_addr, state FETCH.
REQ-027 During redirect, no push SHALL occur; a coincident pop SHALL be discarded by the flush.
REQ-028 redirect_addr >= MEM_DEPTH SHALL load PC=0.
REQ-029 Redirect in IDLE SHALL load the PC only, and the state remains IDLE.
REQ-030 start in FETCH SHALL be ignored; redirect and start asserted together SHALL be treated as redirect.
REQ-031 Fetch latency SHALL be one cycle: an instruction at mem_addr at edge N is visible on dec_inst after edge N, when the FIFO was empty.

Reset
REQ-032 While rst_n=0, the block SHALL immediately and asynchronously set state=IDLE, PC=0, and FIFO count=0 with read/write pointers 0.
REQ-033 During reset, outputs SHALL be: mem_addr=0, dec_valid=0, halted=0, busy=0, and dec_inst/dec_pc = head entry, don't-care while dec_valid=0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered instructions; fetching SHALL restart only on a new start.

Verification
REQ-035 Reset, start, dec_ready=1, memory words 0..3 non-halt: dec_pc SHALL be 0,1,2,3 on consecutive cycles from the cycle after start, and busy=1.
REQ-036 dec_ready=0 for 5 cycles after start: count saturates at 2, mem_addr holds at 2, and dec_inst=mem[0] stays stable; on release, dec_pc SHALL be 0,1,2 without loss.
REQ-037 Word 4 = 16'hF000: after the push of address 4, halted=1 and mem_addr=5; the FIFO drains; start then resumes with dec_pc=5.
REQ-038 With MEM_DEPTH=10, fetching reaches address 9: the next mem_addr SHALL be 0 and the next dec_pc=0.
REQ-039 redirect=1, redirect_addr=7, coincident with a pop and FIFO count=2: next cycle count=0 and mem_addr=7; the following cycle dec_pc=7.
REQ-040 redirect_addr=9'h1FF: PC SHALL load 0; rst_n pulsed low mid-fetch: dec_valid=0 and mem_addr=0 immediately, without waiting for a clock.
